// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle to capture the ALU result, then a
// per-requester valid/ready response. Optional macro DIV0_FLAG_EN turns a
// divide-by-zero request (op 4'b0100, b == 0) into rsp_data = all ones with
// rsp_err = 1; without it rsp_err is tied low and alu_out is passed through.
module alu_arbiter #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned RES_W  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [OP_W-1:0]   alu_op,
    input  logic [RES_W-1:0]  alu_out,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              rsp_take;

`ifdef DIV0_FLAG_EN
    localparam logic [OP_W-1:0] OP_DIV = OP_W'(4'b0100);
    logic div0;
    logic sel_div0;
`endif

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Operation fields of the granted requester
    always_comb begin
        sel_op = grant1 ? req1_op : req0_op;
        sel_a  = grant1 ? req1_a  : req0_a;
        sel_b  = grant1 ? req1_b  : req0_b;
    end

`ifdef DIV0_FLAG_EN
    // Divide-by-zero detection on the operation being accepted
    always_comb begin
        sel_div0 = (sel_op == OP_DIV) && (sel_b == DATA_W'(0));
    end
`endif

    assign accept     = (state == IDLE) && (grant0 || grant1);
    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign rsp_take   = owner ? rsp1_ready : rsp0_ready;
    assign busy       = (state != IDLE);

`ifndef DIV0_FLAG_EN
    assign rsp_err = 1'b0;
`endif

    // Arbitration FSM with registered ALU drive, response and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_op     <= '0;
            rsp_data   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            op_count   <= '0;
`ifdef DIV0_FLAG_EN
            div0       <= 1'b0;
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_op     <= sel_op;
                        alu_in1    <= sel_a;
                        alu_in2    <= sel_b;
                        owner      <= grant1;
                        last_grant <= grant1;
`ifdef DIV0_FLAG_EN
                        div0       <= sel_div0;
`endif
                        state      <= EXEC;
                    end
                end
                EXEC: begin
`ifdef DIV0_FLAG_EN
                    if (div0) begin
                        rsp_data <= {RES_W{1'b1}};
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_data <= alu_out;
                        rsp_err  <= 1'b0;
                    end
`else
                    rsp_data <= alu_out;
`endif
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        op_count   <= op_count + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, abort, contention, alternation,
// response backpressure, an op table and counter wrap (second instance, CNT_W=2).
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_op, req0_a, req0_b;
    logic [3:0] req1_op, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [3:0] alu_in1, alu_in2, alu_op;
    logic [7:0] alu_out;
    logic       busy;
    logic [15:0] op_count;

    logic       w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid;
    logic [7:0] w_rsp_data;
    logic       w_rsp_err, w_busy;
    logic [3:0] w_alu_in1, w_alu_in2, w_alu_op;
    logic [7:0] w_alu_out;
    logic [1:0] w_op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    // Reference ALU (the block under test only drives and samples it)
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'h1:    return 8'(a) + 8'(b);
            4'h2:    return 8'(a) - 8'(b);
            4'h3:    return 8'(a) * 8'(b);
            4'h4:    return (b == 4'd0) ? 8'h00 : 8'(a / b);
            4'h5:    return 8'(a & b);
            4'h6:    return 8'(a | b);
            4'hA:    return 8'(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_out   = alu_f(alu_op, alu_in1, alu_in2);
    assign w_alu_out = alu_f(w_alu_op, w_alu_in1, w_alu_in2);

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(w_rsp_data), .rsp_err(w_rsp_err),
        .alu_in1(w_alu_in1), .alu_in2(w_alu_in2), .alu_op(w_alu_op), .alu_out(w_alu_out),
        .busy(w_busy), .op_count(w_op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit rq, input logic v, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        if (rq) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    // One complete transaction on requester rq with only that requester active
    task automatic do_op(input bit rq, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] edata, input logic eerr, input bit chk_data);
        set_req(rq, 1'b1, op, a, b);
        #1;
        check("op_req_ready", rq ? req1_ready : req0_ready, 1);
        check("op_other_ready", rq ? req0_ready : req1_ready, 0);
        tick();
        set_req(rq, 1'b0, 4'h0, 4'h0, 4'h0);
        check("op_exec_busy", busy, 1);
        check("op_exec_no_rsp", rq ? rsp1_valid : rsp0_valid, 0);
        tick();
        check("op_rsp_valid", rq ? rsp1_valid : rsp0_valid, 1);
        check("op_rsp_other", rq ? rsp0_valid : rsp1_valid, 0);
        if (chk_data) check("op_rsp_data", rsp_data, edata);
        check("op_rsp_err", rsp_err, eerr);
        if (rq) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        exp_cnt++;
        check("op_count", op_count, exp_cnt);
        check("op_count_w2", w_op_count, exp_cnt % 4);
        check("op_idle_valid", rq ? rsp1_valid : rsp0_valid, 0);
        check("op_idle_busy", busy, 0);
        check("op_alu_hold", {alu_op, alu_in1, alu_in2}, {op, a, b});
    endtask

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] data;
        logic       err;
        bit         chk_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{op: 4'h1, a: 4'd7, b: 4'd9, data: 8'h10, err: 1'b0, chk_data: 1'b1};
        vecs[1] = '{op: 4'h3, a: 4'd3, b: 4'd5, data: 8'h0F, err: 1'b0, chk_data: 1'b1};
        vecs[2] = '{op: 4'hA, a: 4'hC, b: 4'hA, data: 8'h06, err: 1'b0, chk_data: 1'b1};
        vecs[3] = '{op: 4'h4, a: 4'd9, b: 4'd2, data: 8'h04, err: 1'b0, chk_data: 1'b1};
        vecs[4] = '{op: 4'h0, a: 4'd5, b: 4'd6, data: 8'h00, err: 1'b0, chk_data: 1'b1};
        vecs[5] = '{op: 4'h2, a: 4'd9, b: 4'd3, data: 8'h06, err: 1'b0, chk_data: 1'b1};
`ifdef DIV0_FLAG_EN
        vecs[6] = '{op: 4'h4, a: 4'd9, b: 4'd0, data: 8'hFF, err: 1'b1, chk_data: 1'b1};
`else
        vecs[6] = '{op: 4'h4, a: 4'd9, b: 4'd0, data: 8'h00, err: 1'b0, chk_data: 1'b0};
`endif

        set_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        set_req(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        do_reset();

        // Reset values
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_data", {rsp_data, 7'd0, rsp_err}, 0);
        check("rst_alu", {alu_op, alu_in1, alu_in2}, 0);
        check("rst_count", op_count, 0);

        // Reset during EXEC aborts the operation; last_grant goes back to 1
        set_req(1'b0, 1'b1, 4'h1, 4'd7, 4'd9);
        #1;
        check("abort_accept", req0_ready, 1);
        tick();
        set_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        check("abort_in_exec", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valids", {rsp0_valid, rsp1_valid}, 0);
        check("abort_count", op_count, 0);
        check("abort_alu", {alu_op, alu_in1, alu_in2}, 0);
        tick();
        check("abort_no_rsp", {rsp0_valid, rsp1_valid}, 0);

        // Contention: requester 0 wins first, then requester 1
        set_req(1'b0, 1'b1, 4'h3, 4'd3, 4'd5);
        set_req(1'b1, 1'b1, 4'hA, 4'hC, 4'hA);
        #1;
        check("cont_r0_ready", req0_ready, 1);
        check("cont_r1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("cont_exec_r1_wait", req1_ready, 0);
        tick();
        check("cont_rsp0_valid", rsp0_valid, 1);
        check("cont_rsp1_idle", rsp1_valid, 0);
        check("cont_rsp0_data", rsp_data, 8'h0F);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        exp_cnt++;
        check("cont_count1", op_count, exp_cnt);
        #1;
        check("cont_r1_ready", req1_ready, 1);
        tick();
        tick();
        check("cont_rsp1_valid", rsp1_valid, 1);
        check("cont_rsp1_data", rsp_data, 8'h06);
        tick();
        exp_cnt++;
        check("cont_count2", op_count, exp_cnt);

        // Both held valid with responses always taken: grants alternate 0,1,0,1
        req0_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_r0_ready", req0_ready, (k % 2 == 0) ? 1 : 0);
            check("alt_r1_ready", req1_ready, (k % 2 == 1) ? 1 : 0);
            tick();
            tick();
            check("alt_rsp_owner", {rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("alt_rsp_data", rsp_data, (k % 2 == 0) ? 8'h0F : 8'h06);
            tick();
            exp_cnt++;
        end
        check("alt_count", op_count, exp_cnt);
        set_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        set_req(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();

        // Response backpressure on requester 1 with requester 0 waiting
        set_req(1'b1, 1'b1, 4'h1, 4'd2, 4'd3);
        #1;
        check("bp_accept", req1_ready, 1);
        tick();
        set_req(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        tick();
        set_req(1'b0, 1'b1, 4'h1, 4'd7, 4'd9);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rsp1_valid", rsp1_valid, 1);
            check("bp_rsp_data", rsp_data, 8'h05);
            check("bp_r0_blocked", req0_ready, 0);
            check("bp_busy", busy, 1);
            tick();
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        exp_cnt++;
        check("bp_release_busy", busy, 0);
        check("bp_release_valid", rsp1_valid, 0);
        check("bp_release_count", op_count, exp_cnt);
        #1;
        check("bp_r0_ready", req0_ready, 1);
        tick();
        set_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        tick();
        check("bp_r0_rsp", {rsp0_valid, rsp_data}, {1'b1, 8'h10});
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        exp_cnt++;
        check("bp_final_count", op_count, exp_cnt);

        // Operation table, alternating requesters
        for (int i = 0; i < 7; i++) begin
            do_op(1'(i % 2), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].err, vecs[i].chk_data);
        end

        // Counter wrap: fresh reset, five ops; the CNT_W=2 copy reads 1,2,3,0,1
        do_reset();
        check("wrap_start", w_op_count, 0);
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].err, vecs[i].chk_data);
        end
        check("wrap_final_w2", w_op_count, 1);
        check("wrap_final_w16", op_count, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 4-bit ALU (15 ops, 4-bit operands, 8-bit result) between two requesters.
- Round-robin arbitration, a valid/ready request handshake per requester, and a registered result returned on a per-requester valid/ready response channel.
- Sits between the Basys3 switch/button front-end or a test sequencer and the ALU; drives the ALU operand and opcode inputs from internal registers.

Parameters:
- DATA_W, 4, operand width; must match the ALU operand width.
- OP_W, 4, opcode width; must match the ALU opcode width.
- RES_W, 8, result width; must match the ALU result width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  OP_W  requester 0 opcode.
- req0_a  in  DATA_W  requester 0 operand 1.
- req0_b  in  DATA_W  requester 0 operand 2.
- req1_valid / req1_ready / req1_op / req1_a / req1_b  as above, for requester 1.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp1_valid  out  1  result available for requester 1.
- rsp1_ready  in  1  requester 1 takes the result.
- rsp_data  out  RES_W  registered result, shared by both response channels.
- rsp_err  out  1  error flag for the result (see Optional Feature).
- alu_in1  out  DATA_W  to ALU in1.
- alu_in2  out  DATA_W  to ALU in2.
- alu_op  out  OP_W  to ALU operations.
- alu_out  in  RES_W  from ALU out.
- busy  out  1  high whenever the state is not IDLE.
- op_count  out  CNT_W  number of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - state = IDLE; all valid/ready outputs = 0.
  - rsp_data = 0, rsp_err = 0, alu_in1/alu_in2/alu_op = 0 (ALU default output is 0).
  - op_count = 0, busy = 0.
  - last_grant = 1, so requester 0 wins the first contest.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. Only req0_valid -> 0. Only req1_valid -> 1. Both -> the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && grantN. At most one ready is high in any cycle.
  - On handshake: register op/a/b into the ALU drive registers, record owner, update last_grant, go to EXEC.
- EXEC (one cycle): alu_out is captured into rsp_data, then go to RESP.
- RESP:
  - rspN_valid is high for the owner only. rsp_data and rsp_err are held stable.
  - When rspN_ready is high: valid drops next cycle, op_count increments, state goes to IDLE.
  - Ready of the non-owner is ignored.
- Latency: request handshake at cycle T -> rsp_valid high at T+2. Rsp handshake at cycle R -> next request accepted no earlier than R+1. Peak throughput is one operation per 3 cycles.
- Requesters hold op/a/b stable and keep valid high until ready. The block samples the fields only at the handshake.
- alu_in1/alu_in2/alu_op hold the last issued operation until the next accept (no glitching in RESP/IDLE).
- Opcode 0000 or any unused code is passed through; the result is whatever the ALU returns (0 for 0000).
- A new request arriving during EXEC/RESP waits; req ready stays 0 until IDLE.
- Reset asserted in any state returns to IDLE next edge and discards the in-flight operation. No response is issued for it, and op_count does not increment.
- A simultaneous rsp handshake and a pending request: the request is accepted at the earliest one cycle later, in IDLE.

Optional Feature:
- Macro DIV0_FLAG_EN.
- Defined:
  - At accept, op==4'b0100 with b==0 is flagged.
  - In EXEC, rsp_data = {RES_W{1'b1}} (8'hFF) and rsp_err = 1, instead of alu_out.
  - All other ops set rsp_err = 0.
- Undefined:
  - rsp_data = alu_out for every op, including divide-by-zero (simulation may show X).
  - rsp_err is tied to 0.

Test Plan:
- Single op: req0 op=0001, a=7, b=9 -> req0_ready at T, rsp0_valid at T+2, rsp_data=8'h10; with rsp0_ready=1, op_count=1.
- Contention: req0 and req1 both valid from reset, op=0011, a=3, b=5 (req0) and op=1010, a=4'hC, b=4'hA (req1).
  - Requester 0 is served first (rsp_data=8'h0F), then requester 1 (rsp_data=8'h06).
  - Both held valid: grants alternate 0,1,0,1.
- Response backpressure: rsp1_ready held 0 for 5 cycles. rsp1_valid and rsp_data stay stable, req0_ready stays 0, busy=1. Release -> IDLE next cycle.
- Reset mid-op: rst pulsed in EXEC -> all valids 0, op_count unchanged, next request is served normally with last_grant reset (requester 0 priority).
- Divide by zero: op=0100, a=9, b=0.
  - With DIV0_FLAG_EN: rsp_data=8'hFF, rsp_err=1.
  - Without: rsp_err=0.
  - op=0100, a=9, b=2 -> rsp_data=8'h04, rsp_err=0.
- Counter wrap: CNT_W=2, run 5 ops -> op_count reads 1,2,3,0,1.
